// File: rtl/demux_pkg.sv
// Shared types and constants for the 1-to-2 buffered demultiplexer.
package demux_pkg;

  localparam int DEMUX_WIDTH_DEFAULT = 32;
  localparam int DEMUX_CNT_W         = 16;

  // Occupancy of one 2-entry output buffer.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } buf_state_e;

  // A buffer can take a new word unless both slots are occupied.
  function automatic logic buf_can_push(input buf_state_e st);
    return (st != FULL);
  endfunction

endpackage

// File: rtl/demux_out_buf.sv
// One 2-entry FIFO behind a demux output port.
// The head slot drives the port directly, so data is stable while stalled.
module demux_out_buf
  import demux_pkg::*;
#(
  parameter int WIDTH = DEMUX_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             ready_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o
);

  buf_state_e       state_q;
  logic [WIDTH-1:0] head_q;
  logic [WIDTH-1:0] tail_q;
  logic             push_s;
  logic             pop_s;

  // A push into FULL is blocked upstream; a pop from EMPTY is ignored.
  assign push_s = push_i && buf_can_push(state_q);
  assign pop_s  = ready_i && (state_q != EMPTY);

  // Occupancy FSM with head/tail storage; push+pop at ONE replaces the head.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      head_q  <= {WIDTH{1'b0}};
      tail_q  <= {WIDTH{1'b0}};
    end else begin
      case (state_q)
        EMPTY: begin
          if (push_s) begin
            head_q  <= data_i;
            state_q <= ONE;
          end
        end
        ONE: begin
          if (push_s && pop_s) begin
            head_q <= data_i;
          end else if (push_s) begin
            tail_q  <= data_i;
            state_q <= FULL;
          end else if (pop_s) begin
            state_q <= EMPTY;
          end
        end
        FULL: begin
          if (pop_s) begin
            head_q  <= tail_q;
            state_q <= ONE;
          end
        end
        default: begin
          state_q <= EMPTY;
        end
      endcase
    end
  end

  assign valid_o = (state_q != EMPTY);
  assign data_o  = head_q;
  assign full_o  = (state_q == FULL);

endmodule

// File: rtl/demux1to2_buf.sv
// 1-to-2 demultiplexer with a 2-entry buffer per output port.
// Optional feature: define DEMUX_STATS_EN to enable the per-port
// accepted-transfer counters; otherwise cnt_a/cnt_b are tied to zero.
module demux1to2_buf
  import demux_pkg::*;
#(
  parameter int WIDTH = DEMUX_WIDTH_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   sel,
  input  logic [WIDTH-1:0]       data_in,
  output logic                   out_a_valid,
  output logic                   out_b_valid,
  input  logic                   out_a_ready,
  input  logic                   out_b_ready,
  output logic [WIDTH-1:0]       data_a,
  output logic [WIDTH-1:0]       data_b,
  output logic [DEMUX_CNT_W-1:0] cnt_a,
  output logic [DEMUX_CNT_W-1:0] cnt_b
);

  logic full_a_s;
  logic full_b_s;
  logic accept_s;
  logic push_a_s;
  logic push_b_s;

  // Readiness follows the currently selected buffer only, never downstream ready,
  // so a sel change while stalled is re-evaluated in the same cycle.
  assign in_ready = sel ? !full_b_s : !full_a_s;
  assign accept_s = in_valid && in_ready;
  assign push_a_s = accept_s && !sel;
  assign push_b_s = accept_s && sel;

  demux_out_buf #(.WIDTH(WIDTH)) u_buf_a (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push_a_s),
    .data_i  (data_in),
    .ready_i (out_a_ready),
    .valid_o (out_a_valid),
    .data_o  (data_a),
    .full_o  (full_a_s)
  );

  demux_out_buf #(.WIDTH(WIDTH)) u_buf_b (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push_b_s),
    .data_i  (data_in),
    .ready_i (out_b_ready),
    .valid_o (out_b_valid),
    .data_o  (data_b),
    .full_o  (full_b_s)
  );

`ifdef DEMUX_STATS_EN
  logic [DEMUX_CNT_W-1:0] cnt_a_q;
  logic [DEMUX_CNT_W-1:0] cnt_b_q;
  logic [DEMUX_CNT_W-1:0] cnt_a_d;
  logic [DEMUX_CNT_W-1:0] cnt_b_d;

  // Next counter values; natural 16-bit wrap from FFFF to 0.
  always_comb begin
    cnt_a_d = cnt_a_q;
    cnt_b_d = cnt_b_q;
    if (push_a_s) begin
      cnt_a_d = cnt_a_q + 16'd1;
    end else begin
      cnt_a_d = cnt_a_q;
    end
    if (push_b_s) begin
      cnt_b_d = cnt_b_q + 16'd1;
    end else begin
      cnt_b_d = cnt_b_q;
    end
  end

  // Accepted-transfer counters, cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_a_q <= 16'd0;
      cnt_b_q <= 16'd0;
    end else begin
      cnt_a_q <= cnt_a_d;
      cnt_b_q <= cnt_b_d;
    end
  end

  assign cnt_a = cnt_a_q;
  assign cnt_b = cnt_b_q;
`else
  assign cnt_a = 16'd0;
  assign cnt_b = 16'd0;
`endif

endmodule

// File: tb/tb_demux1to2_buf.sv
// Self-checking bench for demux1to2_buf. Per-port queues model buffer contents.
module tb_demux1to2_buf;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        sel;
  logic [31:0] data_in;
  logic        out_a_valid;
  logic        out_b_valid;
  logic        out_a_ready;
  logic        out_b_ready;
  logic [31:0] data_a;
  logic [31:0] data_b;
  logic [15:0] cnt_a;
  logic [15:0] cnt_b;

  logic [31:0] qa[$];
  logic [31:0] qb[$];
  logic [15:0] exp_cnt_a;
  logic [15:0] exp_cnt_b;
  int          n_tests;
  int          n_failed;

  demux1to2_buf #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .sel         (sel),
    .data_in     (data_in),
    .out_a_valid (out_a_valid),
    .out_b_valid (out_b_valid),
    .out_a_ready (out_a_ready),
    .out_b_ready (out_b_ready),
    .data_a      (data_a),
    .data_b      (data_b),
    .cnt_a       (cnt_a),
    .cnt_b       (cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance one clock; update the scoreboard with what the edge should have done.
  task automatic cycle();
    logic        acc;
    logic        pa;
    logic        pb;
    logic        s;
    logic [31:0] d;
    acc = in_valid && (sel ? (qb.size() < 2) : (qa.size() < 2));
    pa  = out_a_ready && (qa.size() > 0);
    pb  = out_b_ready && (qb.size() > 0);
    s   = sel;
    d   = data_in;
    @(posedge clk);
    #1;
    if (pa) void'(qa.pop_front());
    if (pb) void'(qb.pop_front());
    if (acc) begin
      if (s) begin
        qb.push_back(d);
`ifdef DEMUX_STATS_EN
        exp_cnt_b = exp_cnt_b + 16'd1;
`endif
      end else begin
        qa.push_back(d);
`ifdef DEMUX_STATS_EN
        exp_cnt_a = exp_cnt_a + 16'd1;
`endif
      end
    end
  endtask

  task automatic clear_model();
    qa.delete();
    qb.delete();
    exp_cnt_a = 16'd0;
    exp_cnt_b = 16'd0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; sel = 1'b0; data_in = 32'd0;
    out_a_ready = 1'b0; out_b_ready = 1'b0;
    clear_model();
    #2;
    n_tests++; if (out_a_valid !== 1'b0) begin n_failed++; $display("FAIL reset_a_valid got %b want 0", out_a_valid); end
    n_tests++; if (out_b_valid !== 1'b0) begin n_failed++; $display("FAIL reset_b_valid got %b want 0", out_b_valid); end
    n_tests++; if (data_a !== 32'd0) begin n_failed++; $display("FAIL reset_data_a got %h want 0", data_a); end
    n_tests++; if (data_b !== 32'd0) begin n_failed++; $display("FAIL reset_data_b got %h want 0", data_b); end
    n_tests++; if (cnt_a !== 16'd0 || cnt_b !== 16'd0) begin n_failed++; $display("FAIL reset_cnt got %h/%h want 0/0", cnt_a, cnt_b); end
    @(negedge clk); rst_n = 1'b1; #1;
    n_tests++; if (in_ready !== 1'b1) begin n_failed++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_single_a();
    sel = 1'b0; data_in = 32'hAAAAAAAA; in_valid = 1'b1; out_a_ready = 1'b1; out_b_ready = 1'b0;
    n_tests++; if (in_ready !== 1'b1) begin n_failed++; $display("FAIL single_in_ready got %b want 1", in_ready); end
    cycle();
    in_valid = 1'b0;
    n_tests++; if (out_a_valid !== 1'b1 || data_a !== 32'hAAAAAAAA) begin n_failed++; $display("FAIL single_a_out got %b/%h want 1/aaaaaaaa", out_a_valid, data_a); end
    n_tests++; if (out_b_valid !== 1'b0) begin n_failed++; $display("FAIL single_b_quiet got %b want 0", out_b_valid); end
    cycle();
    n_tests++; if (out_a_valid !== (qa.size() != 0) || out_a_valid !== 1'b0) begin n_failed++; $display("FAIL single_a_drained got %b want 0", out_a_valid); end
    n_tests++; if (out_b_valid !== 1'b0) begin n_failed++; $display("FAIL single_b_quiet2 got %b want 0", out_b_valid); end
    out_a_ready = 1'b0;
  endtask

  task automatic test_fill_b();
    logic [31:0] first_w;
    sel = 1'b1; out_b_ready = 1'b0; out_a_ready = 1'b0; in_valid = 1'b1;
    first_w = 32'h3A3A3A3A;
    for (int i = 0; i < 3; i++) begin
      data_in = first_w + i;
      n_tests++;
      if (in_ready !== (i < 2)) begin n_failed++; $display("FAIL fill_b_in_ready word %0d got %b want %b", i, in_ready, (i < 2)); end
      cycle();
    end
    in_valid = 1'b0;
    n_tests++; if (qb.size() != 2 || out_b_valid !== 1'b1 || data_b !== first_w) begin n_failed++; $display("FAIL fill_b_head got %b/%h want 1/%h", out_b_valid, data_b, first_w); end
    out_b_ready = 1'b1;
    for (int i = 0; i < 4 && qb.size() > 0; i++) begin
      n_tests++;
      if (out_b_valid !== 1'b1 || data_b !== qb[0]) begin n_failed++; $display("FAIL fill_b_order got %b/%h want 1/%h", out_b_valid, data_b, qb[0]); end
      cycle();
    end
    n_tests++; if (out_b_valid !== 1'b0) begin n_failed++; $display("FAIL fill_b_drained got %b want 0", out_b_valid); end
    out_b_ready = 1'b0;
  endtask

  task automatic test_sel_switch();
    out_a_ready = 1'b0; out_b_ready = 1'b0; sel = 1'b0; in_valid = 1'b1;
    data_in = 32'h11110001; cycle();
    data_in = 32'h11110002; cycle();
    data_in = 32'h5EC75EC7;
    n_tests++; if (in_ready !== 1'b0) begin n_failed++; $display("FAIL switch_blocked got %b want 0", in_ready); end
    sel = 1'b1; #1;
    n_tests++; if (in_ready !== 1'b1) begin n_failed++; $display("FAIL switch_ready got %b want 1", in_ready); end
    cycle();
    in_valid = 1'b0;
    n_tests++; if (out_b_valid !== 1'b1 || data_b !== 32'h5EC75EC7) begin n_failed++; $display("FAIL switch_b_word got %b/%h want 1/5ec75ec7", out_b_valid, data_b); end
    n_tests++; if (out_a_valid !== 1'b1 || data_a !== 32'h11110001) begin n_failed++; $display("FAIL switch_a_head got %b/%h want 1/11110001", out_a_valid, data_a); end
    out_a_ready = 1'b1; out_b_ready = 1'b1;
    for (int i = 0; i < 4 && (qa.size() > 0 || qb.size() > 0); i++) begin
      n_tests++;
      if (out_a_valid !== (qa.size() != 0) || (qa.size() != 0 && data_a !== qa[0])) begin n_failed++; $display("FAIL switch_drain_a got %b/%h", out_a_valid, data_a); end
      cycle();
    end
    out_a_ready = 1'b0; out_b_ready = 1'b0;
  endtask

  task automatic test_push_pop_one();
    sel = 1'b0; out_a_ready = 1'b0; in_valid = 1'b1; data_in = 32'hC0DE0001;
    cycle();
    data_in = 32'hC0DE0002; out_a_ready = 1'b1;
    n_tests++; if (in_ready !== 1'b1 || data_a !== 32'hC0DE0001) begin n_failed++; $display("FAIL pp_before got %b/%h want 1/c0de0001", in_ready, data_a); end
    cycle();
    in_valid = 1'b0;
    n_tests++; if (out_a_valid !== 1'b1 || data_a !== 32'hC0DE0002 || qa.size() != 1) begin n_failed++; $display("FAIL pp_head got %b/%h want 1/c0de0002", out_a_valid, data_a); end
    cycle();
    n_tests++; if (out_a_valid !== 1'b0) begin n_failed++; $display("FAIL pp_no_dup got %b want 0", out_a_valid); end
    out_a_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    out_a_ready = 1'b0; out_b_ready = 1'b0; in_valid = 1'b1;
    sel = 1'b0; data_in = 32'hDEAD0001; cycle();
    sel = 1'b1; data_in = 32'hDEAD0002; cycle();
    #2;
    rst_n = 1'b0;
    #1;
    clear_model();
    n_tests++; if (out_a_valid !== 1'b0 || out_b_valid !== 1'b0) begin n_failed++; $display("FAIL async_valid got %b/%b want 0/0", out_a_valid, out_b_valid); end
    n_tests++; if (data_a !== 32'd0 || data_b !== 32'd0) begin n_failed++; $display("FAIL async_data got %h/%h want 0/0", data_a, data_b); end
    n_tests++; if (cnt_a !== 16'd0 || cnt_b !== 16'd0) begin n_failed++; $display("FAIL async_cnt got %h/%h want 0/0", cnt_a, cnt_b); end
    in_valid = 1'b0;
    @(negedge clk); rst_n = 1'b1; #1;
    sel = 1'b1; data_in = 32'hBEEF0001; in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    n_tests++; if (out_b_valid !== 1'b1 || data_b !== 32'hBEEF0001 || out_a_valid !== 1'b0) begin n_failed++; $display("FAIL async_alone got %b/%h/%b want 1/beef0001/0", out_b_valid, data_b, out_a_valid); end
    cycle();
    n_tests++; if (out_b_valid !== 1'b1 || data_b !== 32'hBEEF0001) begin n_failed++; $display("FAIL async_hold got %b/%h want 1/beef0001", out_b_valid, data_b); end
    out_b_ready = 1'b1; cycle();
    n_tests++; if (out_b_valid !== 1'b0 || out_a_valid !== 1'b0) begin n_failed++; $display("FAIL async_no_replay got %b/%b want 0/0", out_a_valid, out_b_valid); end
    out_b_ready = 1'b0;
  endtask

  task automatic test_counters();
    logic [15:0] want_a;
    logic [15:0] want_b;
    @(negedge clk); rst_n = 1'b0; #1; clear_model();
    @(negedge clk); rst_n = 1'b1; #1;
    out_a_ready = 1'b1; out_b_ready = 1'b1; in_valid = 1'b1;
    sel = 1'b0;
    for (int i = 0; i < 5; i++) begin data_in = 32'hA0000000 + i; cycle(); end
    sel = 1'b1;
    for (int i = 0; i < 3; i++) begin data_in = 32'hB0000000 + i; cycle(); end
    in_valid = 1'b0;
    cycle(); cycle();
`ifdef DEMUX_STATS_EN
    want_a = 16'd5; want_b = 16'd3;
`else
    want_a = 16'd0; want_b = 16'd0;
`endif
    n_tests++; if (cnt_a !== exp_cnt_a || cnt_a !== want_a) begin n_failed++; $display("FAIL cnt_a got %0d want %0d", cnt_a, want_a); end
    n_tests++; if (cnt_b !== exp_cnt_b || cnt_b !== want_b) begin n_failed++; $display("FAIL cnt_b got %0d want %0d", cnt_b, want_b); end
    n_tests++; if (out_a_valid !== 1'b0 || out_b_valid !== 1'b0) begin n_failed++; $display("FAIL cnt_drained got %b/%b want 0/0", out_a_valid, out_b_valid); end
  endtask

  initial begin
    n_tests  = 0;
    n_failed = 0;
    test_reset();
    test_single_a();
    test_fill_b();
    test_sel_switch();
    test_push_pop_one();
    test_async_reset();
    test_counters();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
    $finish;
  end

endmodule

// File: doc/demux1to2_buf.md
DEMUX1TO2_BUF -- requirements
Module: demux1to2_buf

Interface
REQ-001 SHALL have parameter: WIDTH, 32, data word width in bits.
REQ-002 SHALL have port: clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: in_valid  input  1  upstream word valid.
REQ-005 SHALL have port: in_ready  output  1  block accepts word this cycle.
REQ-006 SHALL have port: sel  input  1  destination select; 0 = port A, 1 = port B.
REQ-007 SHALL have port: data_in  input  WIDTH  upstream word.
REQ-008 SHALL have ports: out_a_valid, out_b_valid  output  1 each  head word of port buffer valid.
REQ-009 SHALL have ports: out_a_ready, out_b_ready  input  1 each  downstream consumes head word.
REQ-010 SHALL have ports: data_a, data_b  output  WIDTH each  head word of each port buffer.
REQ-011 SHALL have ports: cnt_a, cnt_b  output  16 each  accepted-transfer counters (see Configuration).

Function
REQ-012 SHALL contain one independent 2-entry FIFO buffer per output port, with states EMPTY, ONE and FULL.
REQ-013 SHALL accept an input transfer when in_valid && in_ready; sel and data_in are sampled on that same edge.
REQ-014 SHALL drive in_ready = 1 when the buffer selected by the current sel is not FULL, and 0 otherwise; in_ready SHALL NOT depend on the out_*_ready inputs.
REQ-015 SHALL write an accepted word only into the selected buffer; the other buffer SHALL be unaffected.
REQ-016 SHALL present an accepted word on the data/valid outputs of an EMPTY port on the cycle after acceptance (latency 1).
REQ-017 SHALL pop the head word of a port when out_x_valid && out_x_ready.
REQ-018 Buffer transitions SHALL be: EMPTY+push->ONE; ONE+push->FULL; ONE+pop->EMPTY; ONE+push+pop->ONE; FULL+pop->ONE; FULL with a push and pop in the same cycle cannot occur (REQ-014).
REQ-019 SHALL preserve per-port order; there is no ordering guarantee between ports.
REQ-020 SHALL hold data_x stable while out_x_valid=1 and out_x_ready=0.
REQ-021 SHALL drive out_x_valid = (state != EMPTY); data_x is don't-care when out_x_valid=0.
REQ-022 SHALL ignore out_x_ready while the port is EMPTY.
REQ-023 SHALL treat a sel change while in_valid=1 and in_ready=0 as a new request, with in_ready re-evaluated against the newly selected buffer.

Reset
REQ-024 SHALL, while rst_n=0 and regardless of clk, set both buffers to EMPTY, out_a_valid=out_b_valid=0, data_a=data_b=0 and cnt_a=cnt_b=0.
REQ-025 SHALL discard buffered words on reset mid-operation; none are replayed after release.
REQ-026 SHALL, on the first edge after rst_n deasserts, behave as EMPTY/EMPTY with in_ready=1.

Configuration
REQ-027 SHALL, with DEMUX_STATS_EN defined, increment cnt_a or cnt_b by one per accepted transfer to port A or B, wrapping from 16'hFFFF to 0.
REQ-028 SHALL, without DEMUX_STATS_EN, keep cnt_a and cnt_b ports present, tie them to constant 0, and infer no counter flops.

Structure
REQ-029 SHALL place the buffer-state typedef (EMPTY/ONE/FULL), the default WIDTH and the counter width constant (16) in a shared package, demux_pkg.
REQ-030 SHALL implement each port buffer as one instance of the sub-module demux_out_buf, instantiated twice.

Verification
REQ-031 SHALL cover: reset, then sel=0, data_in=32'hAAAAAAAA, in_valid=1 for 1 cycle, out_a_ready=1 -> next cycle out_a_valid=1 and data_a=32'hAAAAAAAA, with out_b_valid=0 throughout.
REQ-032 SHALL cover: sel=1, data_in=32'h3A3A3A3A, out_b_ready=0, 3 consecutive words -> first 2 accepted, in_ready=0 on the 3rd; after out_b_ready=1, words emerge in order.
REQ-033 SHALL cover: port A FULL with sel=0 blocked, then sel switched to 1 -> in_ready=1 in the same cycle and the word goes to port B.
REQ-034 SHALL cover: port at ONE with a simultaneous push and pop -> state remains ONE, head advances to the new word, no loss or duplication.
REQ-035 SHALL cover: rst_n pulsed low mid-burst, asynchronous to clk -> valids, data and counters immediately 0, and the next accepted word appears alone.
REQ-036 SHALL cover, with DEMUX_STATS_EN: 5 words to A and 3 to B -> cnt_a=5 and cnt_b=3; without the macro -> both counters stay 0.
